// File: rtl/mem_data_unit.sv
// -----------------------------------------------------------------------------
// mem_data_unit
//
// Holds the memory address register (MAR) and memory data register (MDR).
// Both registers load from the internal CPU bus. The unit also runs single
// read or write transactions to external memory over a req/ack handshake.
// A wait-state timeout ends any request that is never acknowledged and flags
// it on err.
//
// Parameters
//   DATA_W   width of MDR, bus and memory data
//   ADDR_W   width of MAR and memory address (must be <= DATA_W)
//   TIMEOUT  maximum REQ cycles without ack before abort (1..255)
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   bus_in                internal bus data
//   mar_le / mdr_le       load MAR / MDR from the bus (idle only)
//   rd_start / wr_start   start a read into MDR / a write of MDR (idle only)
//   mar_out / mdr_out     register contents
//   busy, done, err       status: busy during REQ/FIN, one-cycle done pulse,
//                         sticky timeout/misalignment flag
//   mem_req, mem_we       memory request and direction (we valid with req)
//   mem_addr, mem_wdata   request address and write data
//   mem_rdata, mem_ack    read data and acknowledge from memory
//
// Optional build macro MDU_BYTE_LANE_EN (requires DATA_W = 32):
//   adds size[1:0] (0 byte, 1 half, 2 word), ld_signed and mem_be. Sub-word
//   writes replicate the low MDR byte/half into every lane. Sub-word reads
//   extract the addressed lane with zero or sign extension. Misaligned
//   accesses skip memory and finish at once with err set.
//
// FSM states
//   state  | meaning
//   IDLE   | registers loadable, waiting for rd_start/wr_start
//   REQ    | mem_req asserted, waiting for mem_ack or timeout
//   FIN    | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module mem_data_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mar_le,
  input  logic              mdr_le,
  input  logic              rd_start,
  input  logic              wr_start,
`ifdef MDU_BYTE_LANE_EN
  input  logic [1:0]        size,
  input  logic              ld_signed,
  output logic [DATA_W/8-1:0] mem_be,
`endif
  output logic [ADDR_W-1:0] mar_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Last REQ cycle index; reaching it without ack ends the request.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [DATA_W-1:0] rd_value;
  logic [DATA_W-1:0] wr_value;

`ifdef MDU_BYTE_LANE_EN
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic                misaligned;
  logic [7:0]          rd_byte;
  logic [15:0]         rd_half;
  logic [DATA_W/8-1:0] be_value;

  // Lane extraction and sign/zero extension of read data.
  always_comb begin
    rd_byte  = mem_rdata[7:0];
    rd_half  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rd_value = mem_rdata;
    case (addr_q[1:0])
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    case (size_q)
      2'd0:    rd_value = {{24{sgn_q & rd_byte[7]}}, rd_byte};
      2'd1:    rd_value = {{16{sgn_q & rd_half[15]}}, rd_half};
      default: rd_value = mem_rdata;
    endcase
  end

  // Write data replication and byte enables for the addressed lane.
  always_comb begin
    wr_value = mdr_q;
    be_value = 4'b1111;
    case (size_q)
      2'd0: begin
        wr_value = {4{mdr_q[7:0]}};
        be_value = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        wr_value = {2{mdr_q[15:0]}};
        be_value = addr_q[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wr_value = mdr_q;
        be_value = 4'b1111;
      end
    endcase
  end

  // Alignment is judged on the address being latched this cycle.
  always_comb begin
    case (size)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = start_addr[0];
      default: misaligned = (start_addr[1:0] != 2'd0);
    endcase
  end

  assign mem_be = (state_q == S_REQ) ? be_value : '0;
`else
  assign rd_value = mem_rdata;
  assign wr_value = mdr_q;
`endif

  assign start      = rd_start | wr_start;
  // A MAR load in the start cycle supplies the transaction address directly.
  assign start_addr = mar_le ? bus_in[ADDR_W-1:0] : mar_q;

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
`ifdef MDU_BYTE_LANE_EN
    size_d  = size_q;
    sgn_d   = sgn_q;
`endif
    busy    = 1'b0;
    done    = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mar_le) mar_d = bus_in[ADDR_W-1:0];
        if (mdr_le) mdr_d = bus_in;
        if (start) begin
          addr_d  = start_addr;
          we_d    = ~rd_start;   // read wins when both strobes are high
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
`ifdef MDU_BYTE_LANE_EN
          size_d  = size;
          sgn_d   = ld_signed;
          if (misaligned) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end
`endif
        end
      end

      S_REQ: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = we_q;
        if (mem_ack) begin
          if (!we_q) mdr_d = rd_value;
          state_d = S_FIN;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef MDU_BYTE_LANE_EN
      size_q  <= 2'd2;
      sgn_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`ifdef MDU_BYTE_LANE_EN
      size_q  <= size_d;
      sgn_q   <= sgn_d;
`endif
    end
  end

  assign mar_out   = mar_q;
  assign mdr_out   = mdr_q;
  assign err       = err_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wr_value;

endmodule

// File: tb/tb_mem_data_unit.sv
module tb_mem_data_unit;

  logic        clk;
  logic        reset;
  logic [31:0] bus_in;
  logic        mar_le, mdr_le, rd_start, wr_start;
  logic [31:0] mar_out, mdr_out;
  logic        busy, done, err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef MDU_BYTE_LANE_EN
  logic [1:0]  size;
  logic        ld_signed;
  logic [3:0]  mem_be;
`endif

  typedef struct {
    logic [31:0] mdr;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_data_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_in    (bus_in),
    .mar_le    (mar_le),
    .mdr_le    (mdr_le),
    .rd_start  (rd_start),
    .wr_start  (wr_start),
`ifdef MDU_BYTE_LANE_EN
    .size      (size),
    .ld_signed (ld_signed),
    .mem_be    (mem_be),
`endif
    .mar_out   (mar_out),
    .mdr_out   (mdr_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] mdr, input logic e);
    exp_t x;
    x.mdr = mdr;
    x.err = e;
    sb_q.push_back(x);
  endtask

  // Serves REQ cycles (ack in REQ cycle index ack_at, never if negative)
  // until done appears, then pops and checks the scoreboard.
  task automatic serve(input string tag, input int ack_at, input logic [31:0] rdata,
                       output int req_cycles, output int ticks);
    bit   got;
    exp_t x;
    got = 0;
    req_cycles = 0;
    ticks = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (done) begin
        got = 1;
        if (sb_q.size() == 0) begin
          chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
          x = sb_q.pop_front();
          chk({tag, "_mdr"}, mdr_out, x.mdr);
          chk({tag, "_err"}, {31'd0, err}, {31'd0, x.err});
        end
      end else begin
        if (mem_req) begin
          mem_ack   = (req_cycles == ack_at);
          mem_rdata = rdata;
          req_cycles++;
        end else begin
          mem_ack = 1'b0;
        end
        tick();
        ticks++;
      end
    end
    mem_ack = 1'b0;
    if (!got) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  int rc, tk;

  initial begin
    reset = 1'b1; bus_in = '0; mar_le = 0; mdr_le = 0; rd_start = 0; wr_start = 0;
    mem_rdata = '0; mem_ack = 0;
`ifdef MDU_BYTE_LANE_EN
    size = 2'd2; ld_signed = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_mar", mar_out, 32'h0);
    chk("rst_mdr", mdr_out, 32'h0);
    chk("rst_status", {28'd0, busy, done, err, mem_req}, 32'h0);
    chk("rst_we", {31'd0, mem_we}, 32'h0);

    // Load MAR and MDR, then write
    mar_le = 1; bus_in = 32'h100; tick(); mar_le = 0;
    mdr_le = 1; bus_in = 32'hDEADBEEF; tick(); mdr_le = 0;
    chk("ld_mar", mar_out, 32'h100);
    chk("ld_mdr", mdr_out, 32'hDEADBEEF);
    wr_start = 1; push_exp(32'hDEADBEEF, 1'b0); tick(); wr_start = 0;
    chk("wr_req", {30'd0, mem_req, mem_we}, 32'h3);
    chk("wr_addr", mem_addr, 32'h100);
    chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
    chk("wr_busy", {31'd0, busy}, 32'h1);
    serve("wr", 3, 32'h55555555, rc, tk);
    chk("wr_req_cycles", rc, 32'd4);
    tick();
    chk("wr_done_once", {30'd0, done, busy}, 32'h0);

    // Ack outside REQ is ignored
    mem_ack = 1; mem_rdata = 32'h0BAD0BAD; tick(); tick(); mem_ack = 0;
    chk("idle_ack_mdr", mdr_out, 32'hDEADBEEF);
    chk("idle_ack_done", {30'd0, done, mem_req}, 32'h0);

    // Read acked in first REQ cycle: done two cycles after start
    rd_start = 1; push_exp(32'h12345678, 1'b0); tick(); rd_start = 0;
    chk("rd_we", {30'd0, mem_req, mem_we}, 32'h2);
    serve("rd", 0, 32'h12345678, rc, tk);
    chk("rd_latency", tk, 32'd1);
    tick();

    // Timeout: 15 REQ cycles, err set, MDR unchanged, err sticky
    rd_start = 1; push_exp(32'h12345678, 1'b1); tick(); rd_start = 0;
    serve("to", -1, 32'hFFFF0000, rc, tk);
    chk("to_req_cycles", rc, 32'd15);
    tick(); tick();
    chk("to_err_sticky", {31'd0, err}, 32'h1);
    rd_start = 1; push_exp(32'hCAFEF00D, 1'b0); tick(); rd_start = 0;
    chk("to_err_clear", {31'd0, err}, 32'h0);
    serve("rd2", 0, 32'hCAFEF00D, rc, tk);
    tick();

    // Both starts: read wins; loads and starts ignored while busy
    rd_start = 1; wr_start = 1; push_exp(32'hA5A51234, 1'b0); tick();
    rd_start = 0; wr_start = 0;
    chk("both_we", {30'd0, mem_req, mem_we}, 32'h2);
    mdr_le = 1; mar_le = 1; wr_start = 1; bus_in = 32'hFFFFFFFF; tick();
    mdr_le = 0; mar_le = 0; wr_start = 0;
    chk("busy_mdr_ign", mdr_out, 32'hCAFEF00D);
    chk("busy_mar_ign", mar_out, 32'h100);
    chk("busy_addr_hold", mem_addr, 32'h100);
    serve("both", 0, 32'hA5A51234, rc, tk);
    tick();
    chk("no_queue", {30'd0, busy, mem_req}, 32'h0);

    // mar_le/mdr_le with rd_start in the same cycle
    mar_le = 1; mdr_le = 1; rd_start = 1; bus_in = 32'h200;
    push_exp(32'h0BADF00D, 1'b0); tick();
    mar_le = 0; mdr_le = 0; rd_start = 0;
    chk("same_addr", mem_addr, 32'h200);
    chk("same_mdr_ld", mdr_out, 32'h200);
    serve("same", 1, 32'h0BADF00D, rc, tk);
    tick();

    // Reset during second REQ cycle
    rd_start = 1; tick(); rd_start = 0;
    tick();
    chk("rst_req2_req", {31'd0, mem_req}, 32'h1);
    reset = 1; tick(); reset = 0;
    chk("rstreq_status", {28'd0, busy, done, err, mem_req}, 32'h0);
    chk("rstreq_mdr", mdr_out, 32'h0);
    chk("rstreq_mar", mar_out, 32'h0);
    tick();
    chk("rstreq_no_done", {31'd0, done}, 32'h0);

`ifdef MDU_BYTE_LANE_EN
    // Signed byte read at lane 3
    mar_le = 1; bus_in = 32'h103; rd_start = 1; size = 2'd0; ld_signed = 1;
    push_exp(32'hFFFFFF80, 1'b0); tick();
    mar_le = 0; rd_start = 0;
    chk("bl_be", {28'd0, mem_be}, 32'h8);
    serve("bl_byte", 0, 32'h80000000, rc, tk);
    tick();
    // Misaligned half read: no request, immediate done with err
    mar_le = 1; bus_in = 32'h101; rd_start = 1; size = 2'd1; ld_signed = 0;
    push_exp(32'hFFFFFF80, 1'b1); tick();
    mar_le = 0; rd_start = 0;
    chk("bl_mis_req", {31'd0, mem_req}, 32'h0);
    serve("bl_mis", 0, 32'h0, rc, tk);
    chk("bl_mis_cycles", rc, 32'd0);
    tick();
    size = 2'd2;
`endif

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
